// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with a 2-bit saturating direction
// counter per entry. Combinational lookup for fetch, combinational
// mispredict/redirect for execute, training and statistics on posedge clk.
module branch_predictor #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 30 - IDX_W,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             lookup_en,
    input  logic [31:0]      PC0,
    output logic [31:0]      PC_pred,
    output logic             chose_pred,
    input  logic             upd_valid,
    input  logic             upd_is_branch,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_pred_taken,
    input  logic [31:0]      upd_pred_target,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int unsigned ENTRIES = 1 << IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       cnt_q    [ENTRIES];

    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;

    logic             up_we;
    logic             valid_d;
    logic [TAG_W-1:0] tag_d;
    logic [31:0]      target_d;
    logic [1:0]       cnt_d;

    assign lk_idx = PC0[IDX_W+1:2];
    assign lk_tag = PC0[31:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[31:IDX_W+2];

    // Fetch-side lookup: reads the pre-edge table, no bypass from training
    always_comb begin
        lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        chose_pred = lk_hit && cnt_q[lk_idx][1];
        PC_pred    = chose_pred ? target_q[lk_idx] : PC0 + 32'd4;
    end

    // Resolution check: flush request and the corrected fetch PC
    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = '0;
        if (upd_valid) begin
            if (upd_is_branch) begin
                mispredict = (upd_pred_taken != upd_taken) ||
                             (upd_taken && upd_pred_taken &&
                              (upd_pred_target != upd_target));
            end else begin
                mispredict = upd_pred_taken;
            end
            redirect_pc = (upd_is_branch && upd_taken) ? upd_target
                                                       : upd_pc + 32'd4;
        end
    end

    // Next contents of the entry addressed by the resolved instruction
    always_comb begin
        up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_we    = 1'b0;
        valid_d  = valid_q[up_idx];
        tag_d    = tag_q[up_idx];
        target_d = target_q[up_idx];
        cnt_d    = cnt_q[up_idx];
        if (upd_valid) begin
            if (upd_is_branch) begin
                if (up_hit) begin
                    up_we = 1'b1;
                    if (upd_taken) begin
                        cnt_d    = (cnt_q[up_idx] != 2'b11) ? cnt_q[up_idx] + 2'd1 : cnt_q[up_idx];
                        target_d = upd_target;
                    end else begin
                        cnt_d    = (cnt_q[up_idx] != 2'b00) ? cnt_q[up_idx] - 2'd1 : cnt_q[up_idx];
                    end
                end else if (upd_taken) begin
                    up_we    = 1'b1;
                    valid_d  = 1'b1;
                    tag_d    = up_tag;
                    target_d = upd_target;
                    cnt_d    = 2'b10;
                end
            end else if (up_hit) begin
                up_we   = 1'b1;
                valid_d = 1'b0;
            end
        end
    end

    // Table storage: reset clears valid bits and sets counters weakly not-taken
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= 2'b01;
            end
        end else if (up_we) begin
            valid_q[up_idx]  <= valid_d;
            tag_q[up_idx]    <= tag_d;
            target_q[up_idx] <= target_d;
            cnt_q[up_idx]    <= cnt_d;
        end
    end

    // Saturating statistics increments
    always_comb begin
        hit_count_d        = hit_count_q;
        mispredict_count_d = mispredict_count_q;
        if (lookup_en && lk_hit && (hit_count_q != '1))
            hit_count_d = hit_count_q + CNT_W'(1);
        if (mispredict && (mispredict_count_q != '1))
            mispredict_count_d = mispredict_count_q + CNT_W'(1);
    end

    // Statistics registers
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            hit_count_q        <= '0;
            mispredict_count_q <= '0;
        end else begin
            hit_count_q        <= hit_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign hit_count        = hit_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios followed by random traffic,
// all checked against a behavioural table model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic        lookup_en;
    logic [31:0] PC0;
    logic [31:0] PC_pred;
    logic        chose_pred;
    logic        upd_valid, upd_is_branch, upd_taken, upd_pred_taken;
    logic [31:0] upd_pc, upd_target, upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] hit_count, mispredict_count;

    int tests = 0;
    int fails = 0;

    branch_predictor #(.IDX_W(6), .TAG_W(24), .CNT_W(32)) dut (
        .clk(clk), .clear(clear), .lookup_en(lookup_en), .PC0(PC0),
        .PC_pred(PC_pred), .chose_pred(chose_pred),
        .upd_valid(upd_valid), .upd_is_branch(upd_is_branch), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .hit_count(hit_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: 64 entries, index = (pc/4) mod 64, tag = pc/256
    bit             m_valid [64];
    int unsigned    m_tag   [64];
    logic [31:0]    m_tgt   [64];
    int             m_cnt   [64];
    longint         m_hits, m_misp;
    logic           e_hit, e_chose, e_mp;
    logic [31:0]    e_pred, e_rd;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc >> 8;
    endfunction

    function automatic bit m_lookup_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 0;
            m_cnt[i]   = 1;
        end
        m_hits = 0;
        m_misp = 0;
    endtask

    task automatic model_train();
        int  i;
        bit  h;
        i = idx_of(upd_pc);
        h = m_lookup_hit(upd_pc);
        if (!upd_valid) return;
        if (upd_is_branch) begin
            if (h && upd_taken) begin
                if (m_cnt[i] < 3) m_cnt[i]++;
                m_tgt[i] = upd_target;
            end else if (h) begin
                if (m_cnt[i] > 0) m_cnt[i]--;
            end else if (upd_taken) begin
                m_valid[i] = 1;
                m_tag[i]   = tag_of(upd_pc);
                m_tgt[i]   = upd_target;
                m_cnt[i]   = 2;
            end
        end else if (h) begin
            m_valid[i] = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic le, input logic [31:0] pc0,
                         input logic v, input logic b, input logic [31:0] upc,
                         input logic t, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptgt);
        lookup_en       = le;
        PC0             = pc0;
        upd_valid       = v;
        upd_is_branch   = b;
        upd_pc          = upc;
        upd_taken       = t;
        upd_target      = tgt;
        upd_pred_taken  = pt;
        upd_pred_target = ptgt;
    endtask

    task automatic idle(input logic [31:0] pc0);
        drive(1'b1, pc0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Let combinational outputs settle, then compare against the model
    task automatic check_comb(input string tg);
        #1;
        e_hit   = m_lookup_hit(PC0);
        e_chose = e_hit && (m_cnt[idx_of(PC0)] >= 2);
        e_pred  = e_chose ? m_tgt[idx_of(PC0)] : PC0 + 32'd4;
        if (!upd_valid) begin
            e_mp = 0;
            e_rd = 32'h0;
        end else begin
            if (upd_is_branch)
                e_mp = (upd_pred_taken != upd_taken) ||
                       (upd_taken && upd_pred_taken && (upd_pred_target != upd_target));
            else
                e_mp = upd_pred_taken;
            e_rd = (upd_is_branch && upd_taken) ? upd_target : upd_pc + 32'd4;
        end
        chk({tg, ".chose"},    {31'h0, chose_pred}, {31'h0, e_chose});
        chk({tg, ".pred"},     PC_pred, e_pred);
        chk({tg, ".misp"},     {31'h0, mispredict}, {31'h0, e_mp});
        chk({tg, ".redirect"}, redirect_pc, e_rd);
    endtask

    // Take one clock edge, update the model, check statistics after it
    task automatic advance(input string tg);
        @(posedge clk);
        if (lookup_en && e_hit && m_hits < 64'hFFFF_FFFF) m_hits++;
        if (e_mp && m_misp < 64'hFFFF_FFFF) m_misp++;
        model_train();
        @(negedge clk);
        chk({tg, ".hitcnt"},  hit_count, 32'(m_hits));
        chk({tg, ".mispcnt"}, mispredict_count, 32'(m_misp));
    endtask

    task automatic cyc(input string tg);
        check_comb(tg);
        advance(tg);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
        p = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
        return p;
    endfunction

    initial begin
        logic [31:0] upc, tgt, ptgt;
        logic        pt, ub, ut, uv;

        idle(32'h40);
        model_reset();
        @(negedge clk);

        // Asynchronous reset between edges
        clear = 1'b1;
        #1;
        chk("rst.chose",   {31'h0, chose_pred}, 32'h0);
        chk("rst.pred",    PC_pred, 32'h44);
        chk("rst.hitcnt",  hit_count, 32'h0);
        chk("rst.mispcnt", mispredict_count, 32'h0);
        clear = 1'b0;
        cyc("rst_after");

        // Cold taken branch allocates
        drive(1, 32'h40, 1, 1, 32'h40, 1, 32'h100, 0, 32'h44);
        check_comb("cold");
        chk("cold.misp_lit",  {31'h0, mispredict}, 32'h1);
        chk("cold.redir_lit", redirect_pc, 32'h100);
        advance("cold");
        idle(32'h40);
        check_comb("cold_hit");
        chk("cold_hit.chose_lit", {31'h0, chose_pred}, 32'h1);
        chk("cold_hit.pred_lit",  PC_pred, 32'h100);
        advance("cold_hit");
        chk("cold_hit.hitcnt_lit", hit_count, 32'h1);

        // Saturate, then two not-taken steps of hysteresis
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h40, 1, 1, 32'h40, 1, 32'h100, 1, 32'h100);
            cyc("sat");
        end
        drive(1, 32'h40, 1, 1, 32'h40, 0, 32'h0, 1, 32'h100);
        check_comb("nt1");
        chk("nt1.misp_lit",  {31'h0, mispredict}, 32'h1);
        chk("nt1.redir_lit", redirect_pc, 32'h44);
        advance("nt1");
        idle(32'h40);
        check_comb("nt1_look");
        chk("nt1_look.chose_lit", {31'h0, chose_pred}, 32'h1);
        advance("nt1_look");
        drive(1, 32'h40, 1, 1, 32'h40, 0, 32'h0, 1, 32'h100);
        cyc("nt2");
        idle(32'h40);
        check_comb("nt2_look");
        chk("nt2_look.chose_lit", {31'h0, chose_pred}, 32'h0);
        advance("nt2_look");

        // Alias eviction and non-branch invalidation
        drive(1, 32'h140, 1, 1, 32'h140, 1, 32'h200, 0, 32'h0);
        cyc("evict");
        idle(32'h40);
        check_comb("evict_old");
        chk("evict_old.chose_lit", {31'h0, chose_pred}, 32'h0);
        advance("evict_old");
        idle(32'h140);
        check_comb("evict_new");
        chk("evict_new.pred_lit", PC_pred, 32'h200);
        advance("evict_new");
        drive(1, 32'h140, 1, 0, 32'h140, 0, 32'h0, 1, 32'h200);
        check_comb("alias");
        chk("alias.misp_lit",  {31'h0, mispredict}, 32'h1);
        chk("alias.redir_lit", redirect_pc, 32'h144);
        advance("alias");
        idle(32'h140);
        check_comb("alias_look");
        chk("alias_look.chose_lit", {31'h0, chose_pred}, 32'h0);
        advance("alias_look");

        // Same-cycle lookup and update: no bypass
        drive(1, 32'h40, 1, 1, 32'h40, 1, 32'h80, 0, 32'h0);
        check_comb("coll");
        chk("coll.pred_lit", PC_pred, 32'h44);
        advance("coll");
        idle(32'h40);
        check_comb("coll_next");
        chk("coll_next.pred_lit", PC_pred, 32'h80);
        advance("coll_next");

        // Wrong target, then wrap-around redirect
        drive(1, 32'h40, 1, 1, 32'h40, 1, 32'h180, 1, 32'h100);
        check_comb("wtgt");
        chk("wtgt.misp_lit",  {31'h0, mispredict}, 32'h1);
        chk("wtgt.redir_lit", redirect_pc, 32'h180);
        advance("wtgt");
        idle(32'h40);
        check_comb("wtgt_look");
        chk("wtgt_look.pred_lit", PC_pred, 32'h180);
        advance("wtgt_look");
        drive(1, 32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h0);
        check_comb("wrap");
        chk("wrap.redir_lit", redirect_pc, 32'h0);
        chk("wrap.pred_lit",  PC_pred, 32'h0);
        advance("wrap");

        // Reset mid-operation discards training without a clock edge
        idle(32'h40);
        clear = 1'b1;
        #1;
        chk("midrst.chose",   {31'h0, chose_pred}, 32'h0);
        chk("midrst.pred",    PC_pred, 32'h44);
        chk("midrst.hitcnt",  hit_count, 32'h0);
        chk("midrst.mispcnt", mispredict_count, 32'h0);
        clear = 1'b0;
        model_reset();
        cyc("midrst_after");

        // Random traffic over a few aliasing tags and indices
        for (int n = 0; n < 1500; n++) begin
            upc = rand_pc();
            uv  = ($urandom_range(0, 4) != 0);
            ub  = ($urandom_range(0, 3) != 0);
            ut  = 1'($urandom_range(0, 1));
            tgt = ($urandom_range(0, 1) != 0) ? rand_pc() : $urandom;
            if ($urandom_range(0, 1) != 0) begin
                pt   = m_lookup_hit(upc) && (m_cnt[idx_of(upc)] >= 2);
                ptgt = pt ? m_tgt[idx_of(upc)] : upc + 32'd4;
            end else begin
                pt   = 1'($urandom_range(0, 1));
                ptgt = ($urandom_range(0, 1) != 0) ? tgt : rand_pc();
            end
            drive(1'($urandom_range(0, 1)), rand_pc(), uv, ub, upc, ut, tgt, pt, ptgt);
            if ($urandom_range(0, 199) == 0) begin
                clear = 1'b1;
                #1;
                clear = 1'b0;
                model_reset();
            end
            cyc("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
